// File: rtl/glitchy_counter_checker_pkg.sv
// Shared constants for the strobe-modulated counter stream: FSM state
// encodings and the expected 8-bit deltas for the default generator.
package glitchy_counter_checker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY   = 2'd0;
  localparam state_t ST_HUNT    = 2'd1;
  localparam state_t ST_LOCKING = 2'd2;
  localparam state_t ST_LOCKED  = 2'd3;

  // Expected modulo-256 deltas for the default generator (+2 / -5).
  localparam logic [7:0] EXP_INC = 8'(2);
  localparam logic [7:0] EXP_DEC = 8'(-5);

  // Delta seen on a non-strobe sample for an arbitrary increment.
  function automatic logic [7:0] exp_inc_f(input int inc);
    return 8'(inc);
  endfunction

  // Delta seen on a strobe sample for an arbitrary decrement.
  function automatic logic [7:0] exp_dec_f(input int dec);
    return 8'(-dec);
  endfunction

endpackage

// File: rtl/glitchy_counter_checker_delta_classify.sv
// Combinational classifier: compares the modulo-256 step from the previous
// sample to the current one against the two legal generator steps.
module glitchy_delta_classify
  import glitchy_counter_checker_pkg::*;
#(
  parameter logic [7:0] EXP_INC_P = EXP_INC,
  parameter logic [7:0] EXP_DEC_P = EXP_DEC
) (
  input  logic [7:0] prev_i,
  input  logic [7:0] cnt_i,
  output logic       is_inc_o,
  output logic       is_dec_o
);

  logic [7:0] delta;

  // Wrapping subtraction makes FE->00 and 02->FD ordinary steps.
  always_comb begin
    delta    = cnt_i - prev_i;
    is_inc_o = (delta == EXP_INC_P);
    is_dec_o = (delta == EXP_DEC_P);
  end

endmodule

// File: rtl/glitchy_counter_checker.sv
// Receive-side checker for the strobe-modulated counter stream. Locks onto
// the strobe phase, regenerates the strobe, and counts deviations once locked.
module glitchy_counter_checker
  import glitchy_counter_checker_pkg::*;
#(
  parameter int PERIOD       = 4,
  parameter int INC          = 2,
  parameter int DEC          = 5,
  parameter int LOCK_PERIODS = 2,
  parameter int ERR_W        = 8
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      cnt_valid,
  input  logic [7:0]                cnt_in,
  output logic                      strobe_out,
  output logic                      locked,
  output logic [$clog2(PERIOD)-1:0] phase,
  output logic                      err_pulse,
  output logic [ERR_W-1:0]          err_count
);

  localparam int PH_W = $clog2(PERIOD);
  localparam int PC_W = $clog2(LOCK_PERIODS + 1);

  state_t            state_q, state_d;
  logic [7:0]        prev_q, prev_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              strobe_q, strobe_d;
  logic              errp_q, errp_d;
  logic [ERR_W-1:0]  errc_q, errc_d;

  logic              is_inc;
  logic              is_dec;
  logic [PH_W-1:0]   phase_nxt;
  logic [PC_W-1:0]   pc_inc;
  logic              exp_dec;
  logic              match;

  glitchy_delta_classify #(
    .EXP_INC_P (exp_inc_f(INC)),
    .EXP_DEC_P (exp_dec_f(DEC))
  ) u_classify (
    .prev_i   (prev_q),
    .cnt_i    (cnt_in),
    .is_inc_o (is_inc),
    .is_dec_o (is_dec)
  );

  // Prediction: the sample landing on phase 0 must be the strobe step.
  always_comb begin
    phase_nxt = (phase_q == PH_W'(PERIOD - 1)) ? '0 : phase_q + 1'b1;
    pc_inc    = pc_q + 1'b1;
    exp_dec   = (phase_nxt == '0);
    match     = exp_dec ? is_dec : is_inc;
  end

  // Next-state logic: only valid samples move state; pulses default low.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    phase_d  = phase_q;
    pc_d     = pc_q;
    errc_d   = errc_q;
    strobe_d = 1'b0;
    errp_d   = 1'b0;
    if (cnt_valid) begin
      prev_d = cnt_in;
      case (state_q)
        ST_EMPTY: begin
          // First sample only seeds prev; nothing to judge it against.
          state_d = ST_HUNT;
        end
        ST_HUNT: begin
          if (is_dec) begin
            state_d = ST_LOCKING;
            phase_d = '0;
            pc_d    = '0;
          end
        end
        ST_LOCKING, ST_LOCKED: begin
          if (match) begin
            phase_d = phase_nxt;
            if (exp_dec) begin
              strobe_d = 1'b1;
              if (state_q == ST_LOCKING) begin
                pc_d = pc_inc;
                if (pc_inc == PC_W'(LOCK_PERIODS)) begin
                  state_d = ST_LOCKED;
                end
              end
            end
          end else begin
            if (state_q == ST_LOCKED) begin
              errp_d = 1'b1;
              errc_d = (&errc_q) ? errc_q : errc_q + 1'b1;
            end
            // An unexpected strobe step is still a strobe: resync on it.
            if (is_dec) begin
              state_d  = ST_LOCKING;
              phase_d  = '0;
              pc_d     = '0;
              strobe_d = 1'b1;
            end else begin
              state_d = ST_HUNT;
              phase_d = '0;
              pc_d    = '0;
            end
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      prev_q   <= 8'h00;
      phase_q  <= '0;
      pc_q     <= '0;
      strobe_q <= 1'b0;
      errp_q   <= 1'b0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      strobe_q <= strobe_d;
      errp_q   <= errp_d;
      errc_q   <= errc_d;
    end
  end

  assign strobe_out = strobe_q;
  assign err_pulse  = errp_q;
  assign err_count  = errc_q;
  assign phase      = phase_q;
  assign locked     = (state_q == ST_LOCKED);

endmodule

// File: doc/glitchy_counter_checker.md
# glitchy_counter_checker

Receive-side checker for the 8-bit strobe-modulated counter stream produced by the clock-strobe generator. Every cycle that generator adds 2, except on a divide-by-4 strobe cycle where it subtracts 5. This block samples that stream, locks onto the strobe phase, and regenerates the one-cycle strobe. It flags and counts every deviation from the expected sequence and sits next to the generator as its self-test / link monitor.

## Interface
- PERIOD, 4: strobe period in clk_in cycles (generator's divide ratio); ≥2
- INC, 2: per-cycle increment on non-strobe samples
- DEC, 5: decrement applied on strobe samples
- LOCK_PERIODS, 2: consecutive clean periods required to declare lock; ≥1
- ERR_W, 8: width of error counter
- clk_in  input  1  single system clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- cnt_valid  input  1  cnt_in is a new sample this cycle
- cnt_in  input  8  counter value from generator
- strobe_out  output  1  recovered strobe, one-cycle pulse
- locked  output  1  phase lock established
- phase  output  $clog2(PERIOD)  current position in strobe period; 0 = strobe sample
- err_pulse  output  1  one-cycle pulse per mismatch while locked
- err_count  output  ERR_W  saturating mismatch count

## Operation
- All arithmetic is modulo 256: delta = cnt_in − prev (8-bit wrap). Expected strobe delta = 8'(−DEC) = 8'hFB. Expected non-strobe delta = 8'(INC) = 8'h02.
- prev register: loaded with cnt_in on every valid sample, in every state. Cycles with cnt_valid low change no state, counter or prev; outputs pulse low.
- FSM states: EMPTY, HUNT, LOCKING, LOCKED.
  - EMPTY: no prev yet. First valid sample loads prev → HUNT.
  - HUNT: delta == FB → LOCKING, phase ← 0, period_cnt ← 0. Any other delta: stay in HUNT.
  - LOCKING: expected delta is FB when the next phase is 0, else 02. On match, phase advances modulo PERIOD. Each return to phase 0 increments period_cnt. When period_cnt reaches LOCK_PERIODS → LOCKED. On mismatch → HUNT, with no error counted. If the mismatching delta is FB, go directly to LOCKING with phase 0 (resync).
  - LOCKED: same prediction rule. On mismatch: err_pulse=1, err_count += 1 (saturating at all-ones), → HUNT (or LOCKING if delta == FB, as above).
- strobe_out: pulses on each valid sample with delta == FB accepted as phase 0, in LOCKING or LOCKED. Never pulses in EMPTY or HUNT.
- locked = (state == LOCKED).
- Reset values: state EMPTY, prev 0, phase 0, period_cnt 0, strobe_out 0, locked 0, err_pulse 0, err_count 0.

## Timing
- All outputs are registered. The response to a sample at edge N is visible after edge N+1 (latency 1).
- Lock time from a clean stream: 1 sample (EMPTY) + hunt to first strobe + LOCK_PERIODS×PERIOD samples. With defaults and a stream starting on a strobe sample, locked rises at the 10th valid sample's update.
- err_pulse and the state change to HUNT occur on the same edge. locked falls on that edge.
- Simultaneous mismatch and saturated err_count: err_pulse still asserts and the count holds.
- Asynchronous reset deasserted mid-stream: restart in EMPTY. The first post-reset sample is never judged.
- Counter wrap (e.g. FE → 00 on +2, 02 → FD on −5) is not an error.

## Structure
- A shared package holds the state enum (EMPTY/HUNT/LOCKING/LOCKED) and the derived constants EXP_INC = 8'(INC) and EXP_DEC = 8'(−DEC). The generator testbench uses the same constants.
- One natural sub-module: glitchy_delta_classify. It is combinational and takes prev, cnt_in → is_inc, is_dec. The FSM, phase/period counters and error counter stay in the top.

## Test plan
- Reset, then clean generator stream starting at 00 with strobe first (FB, FD, FF, 01, FC, ...) → locked=1 after sample 10; strobe_out pulses every 4th valid sample; err_count=0.
- Locked, then inject one corrupted sample (+3 instead of +2) → err_pulse for one cycle, err_count=1, locked=0. Relock after the next strobe plus 2 clean periods.
- Counter crosses FF→00 and 01→FC while locked → no err_pulse.
- cnt_valid low for 5 cycles mid-period while locked → phase, prev and locked unchanged; no pulses; resumes with no error.
- Force 300 mismatches with ERR_W=8 → err_count saturates at 8'hFF; err_pulse still asserts on each.
- Assert rst low asynchronously between edges while locked → all outputs 0 immediately, state EMPTY. The first post-reset sample produces no error.
